// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//   Main control FSM of the multicycle RV32I core. Sequences fetch, decode,
//   execute, memory and writeback for lw, sw, R-type, I-type ALU, beq/bne and
//   jal, and drives the datapath mux selects and write strobes. Memory
//   accesses wait on a ready handshake guarded by a timeout watchdog.
//
// Parameters
//   MAX_WAIT     cycles to wait for mem_ready in FETCH/MEMREAD/MEMWRITE (>=1)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   op           in   [6:0] opcode from the instruction register
//   funct3       in   [2:0] instr[14:12] (bit 0 selects beq/bne)
//   zero         in   ALU zero flag
//   mem_ready    in   memory access completes this cycle
//   pcwrite      out  PC register enable
//   adrsrc       out  memory address select (0 PC, 1 ALUOut)
//   irwrite      out  instruction/oldPC register enable
//   memwrite     out  memory write strobe
//   regwrite     out  register file write enable
//   resultsrc    out  [1:0] 00 ALUOut, 01 memdata, 10 ALU result
//   alusrca      out  [1:0] 00 PC, 01 oldPC, 10 rs1
//   alusrcb      out  [1:0] 00 rs2, 01 immext, 10 const 4
//   aluop        out  [1:0] 00 add, 01 sub, 10 decode by funct
//   immsrc       out  [1:0] 00 I, 01 S, 10 B, 11 J
//   illegal_op   out  sticky: unsupported opcode decoded
//   mem_timeout  out  sticky: memory wait expired
//   state_dbg    out  [3:0] current state encoding
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] immsrc,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_dbg
);

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;
    logic            expired;
    logic            pcwrite_c, irwrite_c, memwrite_c, regwrite_c;

    // Only funct3[0] distinguishes beq from bne.
    logic unused_funct3;
    assign unused_funct3 = ^funct3[2:1];

    assign expired = (wait_cnt_q == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        pcwrite_c  = 1'b0;
        adrsrc     = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        aluop      = 2'b00;

        // Waiting states share the handshake: ready advances, otherwise the
        // counter runs until expiry aborts to FETCH. Ready on the expiry
        // cycle takes priority over the abort.
        case (state_q)
            FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite_c = mem_ready;
                pcwrite_c = mem_ready;
                if (mem_ready) begin
                    state_d = DECODE;
                end else if (expired) begin
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_B:         state_d = BRANCH;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adrsrc = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end else if (expired) begin
                    state_d   = FETCH;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            MEMWB: begin
                resultsrc  = 2'b01;
                regwrite_c = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adrsrc     = 1'b1;
                memwrite_c = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end else if (expired) begin
                    state_d   = FETCH;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            EXECR: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
                state_d = ALUWB;
            end
            EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                regwrite_c = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alusrca   = 2'b10;
                aluop     = 2'b01;
                pcwrite_c = zero ^ funct3[0];
                state_d   = FETCH;
            end
            JAL: begin
                alusrca   = 2'b01;
                alusrcb   = 2'b10;
                pcwrite_c = 1'b1;
                state_d   = ALUWB;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_B:    immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    // Write strobes are held off for as long as reset is asserted.
    assign pcwrite     = pcwrite_c  & reset;
    assign irwrite     = irwrite_c  & reset;
    assign memwrite    = memwrite_c & reset;
    assign regwrite    = regwrite_c & reset;
    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       pcwrite, adrsrc, irwrite, memwrite, regwrite;
    logic [1:0] resultsrc, alusrca, alusrcb, aluop, immsrc;
    logic       illegal_op, mem_timeout;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    multicycle_controller #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .pcwrite(pcwrite), .adrsrc(adrsrc),
        .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .immsrc(immsrc), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got hang expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0; op = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        checks++; if (state_dbg !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        checks++; if (illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", illegal_op, mem_timeout); end
        checks++; if (pcwrite !== 1'b0 || irwrite !== 1'b0) begin errors++; $display("FAIL reset_strobes: got pc=%b ir=%b expected 0 0", pcwrite, irwrite); end
        reset = 1'b1;
        #1;
        checks++; if (pcwrite !== 1'b1 || irwrite !== 1'b1) begin errors++; $display("FAIL fetch_strobes: got pc=%b ir=%b expected 1 1", pcwrite, irwrite); end
    endtask

    task automatic test_addi();
        op = 7'b0010011; mem_ready = 1'b1;
        #1;
        checks++; if (state_dbg !== 4'd0 || alusrcb !== 2'b10 || resultsrc !== 2'b10) begin errors++; $display("FAIL addi_fetch: got st=%0d b=%b res=%b expected 0 10 10", state_dbg, alusrcb, resultsrc); end
        checks++; if (immsrc !== 2'b00 || regwrite !== 1'b0) begin errors++; $display("FAIL addi_imm: got imm=%b rw=%b expected 00 0", immsrc, regwrite); end
        tick();
        checks++; if (state_dbg !== 4'd1 || alusrca !== 2'b01 || alusrcb !== 2'b01 || regwrite !== 1'b0) begin errors++; $display("FAIL addi_decode: got st=%0d a=%b b=%b rw=%b expected 1 01 01 0", state_dbg, alusrca, alusrcb, regwrite); end
        tick();
        checks++; if (state_dbg !== 4'd7 || alusrca !== 2'b10 || alusrcb !== 2'b01 || aluop !== 2'b10 || regwrite !== 1'b0) begin errors++; $display("FAIL addi_execi: got st=%0d a=%b b=%b op=%b rw=%b expected 7 10 01 10 0", state_dbg, alusrca, alusrcb, aluop, regwrite); end
        tick();
        checks++; if (state_dbg !== 4'd8 || regwrite !== 1'b1 || resultsrc !== 2'b00) begin errors++; $display("FAIL addi_aluwb: got st=%0d rw=%b res=%b expected 8 1 00", state_dbg, regwrite, resultsrc); end
        tick();
        checks++; if (state_dbg !== 4'd0) begin errors++; $display("FAIL addi_done: got %0d expected 0", state_dbg); end
    endtask

    task automatic test_rtype();
        op = 7'b0110011; mem_ready = 1'b1;
        tick(); tick();
        checks++; if (state_dbg !== 4'd6 || alusrca !== 2'b10 || alusrcb !== 2'b00 || aluop !== 2'b10) begin errors++; $display("FAIL rtype_execr: got st=%0d a=%b b=%b op=%b expected 6 10 00 10", state_dbg, alusrca, alusrcb, aluop); end
        tick();
        checks++; if (state_dbg !== 4'd8 || regwrite !== 1'b1) begin errors++; $display("FAIL rtype_aluwb: got st=%0d rw=%b expected 8 1", state_dbg, regwrite); end
        tick();
    endtask

    task automatic test_lw_wait();
        op = 7'b0000011; mem_ready = 1'b1;
        tick(); tick();
        checks++; if (state_dbg !== 4'd2 || alusrca !== 2'b10 || alusrcb !== 2'b01) begin errors++; $display("FAIL lw_memadr: got st=%0d a=%b b=%b expected 2 10 01", state_dbg, alusrca, alusrcb); end
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (state_dbg !== 4'd3 || adrsrc !== 1'b1 || regwrite !== 1'b0) begin errors++; $display("FAIL lw_wait%0d: got st=%0d adr=%b rw=%b expected 3 1 0", i, state_dbg, adrsrc, regwrite); end
            tick();
        end
        // Fourth cycle is the expiry cycle; ready here must win.
        mem_ready = 1'b1;
        checks++; if (state_dbg !== 4'd3) begin errors++; $display("FAIL lw_wait3: got %0d expected 3", state_dbg); end
        tick();
        checks++; if (state_dbg !== 4'd4 || resultsrc !== 2'b01 || regwrite !== 1'b1 || mem_timeout !== 1'b0) begin errors++; $display("FAIL lw_memwb: got st=%0d res=%b rw=%b to=%b expected 4 01 1 0", state_dbg, resultsrc, regwrite, mem_timeout); end
        tick();
        checks++; if (state_dbg !== 4'd0) begin errors++; $display("FAIL lw_done: got %0d expected 0", state_dbg); end
    endtask

    task automatic test_branch();
        logic [2:0] f3 [3] = '{3'b000, 3'b001, 3'b000};
        logic       zf [3] = '{1'b1, 1'b1, 1'b0};
        logic       exp[3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            op = 7'b1100011; funct3 = f3[i]; zero = zf[i]; mem_ready = 1'b1;
            tick(); tick();
            checks++; if (state_dbg !== 4'd9 || pcwrite !== exp[i] || aluop !== 2'b01 || immsrc !== 2'b10) begin errors++; $display("FAIL branch%0d: got st=%0d pc=%b op=%b imm=%b expected 9 %b 01 10", i, state_dbg, pcwrite, aluop, immsrc, exp[i]); end
            tick();
            checks++; if (state_dbg !== 4'd0) begin errors++; $display("FAIL branch%0d_done: got %0d expected 0", i, state_dbg); end
        end
        funct3 = 3'd0; zero = 1'b0;
    endtask

    task automatic test_jal();
        op = 7'b1101111; mem_ready = 1'b1;
        tick(); tick();
        checks++; if (state_dbg !== 4'd10 || pcwrite !== 1'b1 || alusrca !== 2'b01 || alusrcb !== 2'b10 || immsrc !== 2'b11) begin errors++; $display("FAIL jal_state: got st=%0d pc=%b a=%b b=%b imm=%b expected 10 1 01 10 11", state_dbg, pcwrite, alusrca, alusrcb, immsrc); end
        tick();
        checks++; if (state_dbg !== 4'd8 || regwrite !== 1'b1) begin errors++; $display("FAIL jal_aluwb: got st=%0d rw=%b expected 8 1", state_dbg, regwrite); end
        tick();
    endtask

    task automatic test_sw_timeout();
        op = 7'b0100011; mem_ready = 1'b1;
        #1;
        checks++; if (immsrc !== 2'b01) begin errors++; $display("FAIL sw_imm: got %b expected 01", immsrc); end
        tick(); tick(); tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (state_dbg !== 4'd5 || memwrite !== 1'b1 || mem_timeout !== 1'b0) begin errors++; $display("FAIL sw_write%0d: got st=%0d mw=%b to=%b expected 5 1 0", i, state_dbg, memwrite, mem_timeout); end
            tick();
        end
        checks++; if (state_dbg !== 4'd0 || memwrite !== 1'b0 || mem_timeout !== 1'b1) begin errors++; $display("FAIL sw_timeout: got st=%0d mw=%b to=%b expected 0 0 1", state_dbg, memwrite, mem_timeout); end
        mem_ready = 1'b1;
    endtask

    task automatic test_illegal();
        op = 7'b1111111; mem_ready = 1'b1;
        tick();
        checks++; if (state_dbg !== 4'd1 || illegal_op !== 1'b0) begin errors++; $display("FAIL ill_decode: got st=%0d ill=%b expected 1 0", state_dbg, illegal_op); end
        tick();
        checks++; if (state_dbg !== 4'd0 || illegal_op !== 1'b1 || regwrite !== 1'b0 || memwrite !== 1'b0) begin errors++; $display("FAIL ill_flag: got st=%0d ill=%b rw=%b mw=%b expected 0 1 0 0", state_dbg, illegal_op, regwrite, memwrite); end
        checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL sticky_timeout: got %b expected 1", mem_timeout); end
    endtask

    task automatic test_reset_mid();
        op = 7'b0100011; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        checks++; if (state_dbg !== 4'd5 || memwrite !== 1'b1) begin errors++; $display("FAIL mid_memwrite: got st=%0d mw=%b expected 5 1", state_dbg, memwrite); end
        reset = 1'b0;
        #1;
        checks++; if (memwrite !== 1'b0) begin errors++; $display("FAIL mid_forced: got mw=%b expected 0", memwrite); end
        tick();
        checks++; if (state_dbg !== 4'd0 || memwrite !== 1'b0 || illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin errors++; $display("FAIL mid_reset: got st=%0d mw=%b ill=%b to=%b expected 0 0 0 0", state_dbg, memwrite, illegal_op, mem_timeout); end
        reset = 1'b1; mem_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_jal();
        test_sw_timeout();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
